// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive bit sampler: receiver states,
// default oversampling/character sizes and the 2-of-3 vote helper.
package uart_rx_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_majority3.sv
// Captures the two early mid-bit samples; the third is the live input, so the
// vote is ready on the same tick that takes the last sample.
module uart_rx_majority3
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cap,
  input  logic       din,
  output logic       vote,
  output logic       bit_value
);

  logic [1:0] early_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      early_reg <= 2'b11;
      bit_value <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cap[i]) early_reg[i] <= din;
      end
      if (cap[2]) bit_value <= vote;
    end
  end

  assign vote = maj3(early_reg[0], early_reg[1], din);

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// Oversampling UART receiver: synchronises rx_in, finds the start edge, votes
// three mid-bit samples per bit and assembles LSB-first characters.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rx_in,
  output logic                 sample_strobe,
  output logic                 bit_value,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 char_done,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID_M1   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] MID      = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] MID_P1   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_oversample
    $fatal(1, "uart_rx_bit_sampler: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_rx_bit_sampler: DATA_BITS must be in 5..9");
  end

  logic [1:0]           sync_reg;
  logic                 rx_s;
  rx_state_e            state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_out_reg;
  logic                 frame_error_reg;
  logic                 strobe_reg;
  logic                 char_done_reg;
  logic                 tick;
  logic                 at_wrap;
  logic                 at_sample;
  logic                 vote;
  logic [2:0]           cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= 2'b11;
    else      sync_reg <= {sync_reg[0], rx_in};
  end
  assign rx_s = sync_reg[1];

  assign tick      = enable && (state_reg != ST_IDLE);
  assign at_wrap   = (cnt_reg == CNT_LAST);
  assign at_sample = tick && (cnt_reg == MID_P1);
  assign cap       = {at_sample, tick && (cnt_reg == MID), tick && (cnt_reg == MID_M1)};

  uart_rx_majority3 u_vote (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap),
    .din       (rx_s),
    .vote      (vote),
    .bit_value (bit_value)
  );

  // Later assignments in a state deliberately override earlier ones, so with
  // OVERSAMPLE=4 (sample tick == wrap tick) a false start still wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      shift_reg       <= '0;
      data_out_reg    <= '0;
      frame_error_reg <= 1'b0;
      strobe_reg      <= 1'b0;
      char_done_reg   <= 1'b0;
    end else begin
      strobe_reg    <= at_sample;
      char_done_reg <= 1'b0;
      if (enable) begin
        if (state_reg != ST_IDLE) cnt_reg <= at_wrap ? '0 : cnt_reg + 1'b1;
        case (state_reg)
          ST_IDLE: begin
            if (!rx_s) begin
              state_reg <= ST_START;
              cnt_reg   <= '0;
            end
          end
          ST_START: begin
            if (at_wrap) begin
              state_reg <= ST_DATA;
              idx_reg   <= '0;
            end
            if (at_sample && vote) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
            end
          end
          ST_DATA: begin
            if (at_sample) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
            if (at_wrap) begin
              if (idx_reg == IDX_LAST) state_reg <= ST_STOP;
              else                     idx_reg   <= idx_reg + 1'b1;
            end
          end
          ST_STOP: begin
            // Leave at mid stop bit so the next start edge is never missed.
            if (at_sample) begin
              data_out_reg    <= shift_reg;
              frame_error_reg <= ~vote;
              char_done_reg   <= 1'b1;
              state_reg       <= ST_IDLE;
              cnt_reg         <= '0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign sample_strobe = strobe_reg;
  assign data_out      = data_out_reg;
  assign char_done     = char_done_reg;
  assign frame_error   = frame_error_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: doc/uart_rx_bit_sampler.md
UART_RX_BIT_SAMPLER -- requirements
Module: uart_rx_bit_sampler

Interface
REQ-001 Parameter OVERSAMPLE, default 16: enable ticks per bit; SHALL be even and >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per character; SHALL be 5..9.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  oversample tick, one clk wide; counters advance only on clk edges where enable=1.
REQ-006 rx_in  input  1  asynchronous serial line, idle high.
REQ-007 sample_strobe  output  1  one-clk pulse per sampled bit (start, data, stop).
REQ-008 bit_value  output  1  majority-voted value of the current bit, valid with sample_strobe.
REQ-009 data_out  output  DATA_BITS  last received character, LSB = first data bit.
REQ-010 char_done  output  1  one-clk pulse when data_out and frame_error update.
REQ-011 frame_error  output  1  stop bit of last character sampled low.
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
REQ-014 States: IDLE, START, DATA, STOP.
REQ-015 IDLE: on an enable tick with rx_s=0 -> START, sample_cnt=0.
REQ-016 Outside IDLE, sample_cnt increments per enable tick, width clog2(OVERSAMPLE), and wraps OVERSAMPLE-1 -> 0 at bit end.
REQ-017 MID = OVERSAMPLE/2; rx_s is captured on ticks with sample_cnt = MID-1, MID, MID+1; bit_value = 2-of-3 majority.
REQ-018 sample_strobe SHALL assert the clk after the tick at sample_cnt = MID+1, exactly once per bit.
REQ-019 START: voted 1 at strobe -> IDLE (false start, no char_done); voted 0 -> stay until wrap -> DATA, bit_index=0.
REQ-020 DATA: at each strobe shift bit_value into the shift register LSB-first; at wrap bit_index++; wrap with bit_index = DATA_BITS-1 -> STOP.
REQ-021 STOP: at strobe, data_out <= shift register, frame_error <= ~bit_value, char_done pulses with sample_strobe, state -> IDLE same edge (half-bit early resync).
REQ-022 char_done SHALL never pulse for a false start; frame_error holds until next char_done.
REQ-023 enable=0 SHALL freeze state, sample_cnt, bit_index and the capture registers; synchroniser keeps running.
REQ-024 rx_s low on the IDLE-return edge SHALL NOT start a frame before the next enable tick.
REQ-025 Frame latency: char_done asserted (1 + DATA_BITS) * OVERSAMPLE + MID + 2 enable ticks after the first low tick, plus 1 clk.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, sample_cnt=0, bit_index=0, shift register=0, synchroniser=1s.
REQ-027 Reset values: sample_strobe=0, bit_value=1, data_out=0, char_done=0, frame_error=0, busy=0.
REQ-028 Reset mid-frame SHALL discard the partial character with no char_done; reception resumes on the next falling edge after release.

Structure
REQ-029 Package uart_rx_pkg SHALL hold the state enum and default OVERSAMPLE/DATA_BITS constants.
REQ-030 The 3-sample capture and vote SHALL be sub-module uart_rx_majority3; everything else in one module.
REQ-031 Parameter legality SHALL be checked at elaboration with a fatal message.

Verification (OVERSAMPLE=16, DATA_BITS=8, enable every 4th clk)
REQ-032 Frame 0xA5, stop=1 -> data_out=0xA5, frame_error=0, exactly 10 sample_strobe and 1 char_done.
REQ-033 rx_in low 3 ticks then high -> sample_strobe with bit_value=1, back to IDLE, no char_done, busy falls.
REQ-034 Frame 0x3C with rx_in forced high for the tick at sample_cnt=MID in data bit 2 -> data_out=0x3C (vote rejects glitch).
REQ-035 Frame 0xFF with stop=0 -> data_out=0xFF, frame_error=1; next good frame 0x00 clears frame_error to 0.
REQ-036 rst low during data bit 4, then frame 0x5A -> all outputs at reset values, no char_done until 0x5A completes correctly.
REQ-037 enable held low 50 clk mid-DATA -> no output/state change; resumed frame 0x81 received correctly.
